// File: rtl/ysyx_25020032_pkg.sv
// Shared encodings for the EXU multiply/divide slice: ALU op codes, M-extension op codes, FSM states.
package ysyx_25020032_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Operand signedness per M op; rs1 is signed for MULHSU, rs2 is not.
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ysyx_25020032_mdu_iter.sv
// Radix-2 shift-add multiplier / restoring divider on magnitudes, sign fixed up on the final step.
// Optional YSYX_25020032_EXU_MD_EARLY_EN skips leading-zero dividend bits.
module ysyx_25020032_mdu_iter
  import ysyx_25020032_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            last,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [2:0]      op_reg;
  logic            neg_reg;
  logic [XLEN-1:0] acc_reg, lo_reg, b_reg;
  logic [CW-1:0]   cnt_reg;

  logic            ld_div, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [CW-1:0]   skip;

  assign ld_div = md_op[2];
  assign a_neg  = md_a_signed(md_op) && opa[XLEN-1];
  assign b_neg  = md_b_signed(md_op) && opb[XLEN-1];
  assign a_mag  = a_neg ? -opa : opa;
  assign b_mag  = b_neg ? -opb : opb;

`ifdef YSYX_25020032_EXU_MD_EARLY_EN
  // Zero dividend still takes one step so the minimum latency stays 2.
  function automatic logic [CW-1:0] lead_zeros(input logic [XLEN-1:0] v);
    logic [CW-1:0] lz;
    lz = CW'(XLEN - 1);
    for (int i = 0; i < XLEN; i++)
      if (v[i]) lz = CW'(XLEN - 1 - i);
    return lz;
  endfunction
  assign skip = ld_div ? lead_zeros(a_mag) : '0;
`else
  assign skip = '0;
`endif

  logic [XLEN:0]     sum, rem_sh, diff;
  logic [XLEN-1:0]   acc_n, lo_n, quo, rmd;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sum    = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    rem_sh = {acc_reg, lo_reg[XLEN-1]};
    diff   = rem_sh - {1'b0, b_reg};
    if (op_reg[2]) begin
      acc_n = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_n  = {lo_reg[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_n = sum[XLEN:1];
      lo_n  = {sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // Result is formed from the post-step values so it can be captured on the last step.
  always_comb begin
    prod = {acc_n, lo_n};
    if (neg_reg) prod = -prod;
    quo = neg_reg ? -lo_n : lo_n;
    rmd = neg_reg ? -acc_n : acc_n;
    case (op_reg)
      MD_MUL:                      res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             res = quo;
      default:                     res = rmd;
    endcase
  end

  assign last = step && (cnt_reg == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg  <= '0;
      neg_reg <= 1'b0;
      acc_reg <= '0;
      lo_reg  <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      op_reg  <= md_op;
      neg_reg <= (ld_div && md_op[1]) ? a_neg : (a_neg ^ b_neg);
      acc_reg <= '0;
      b_reg   <= ld_div ? b_mag : a_mag;
      lo_reg  <= ld_div ? (a_mag << skip) : b_mag;
      cnt_reg <= skip;
    end else if (step) begin
      acc_reg <= acc_n;
      lo_reg  <= lo_n;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_25020032_exu_md.sv
// EXU slice: single-cycle ALU plus iterative M-extension unit behind a valid/ready handshake.
// Build option YSYX_25020032_EXU_MD_EARLY_EN enables early divide termination in the iterator.
module ysyx_25020032_exu_md
  import ysyx_25020032_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  md_en,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [2:0]            md_op,
  input  logic [XLEN-1:0]       opa,
  input  logic [XLEN-1:0]       opb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  busy
);
  localparam int SW = $clog2(XLEN);

  md_state_e       state_reg, state_next;
  logic            out_valid_reg, out_valid_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            fire, iter_load, iter_step, iter_last;
  logic [XLEN-1:0] iter_res, alu_res, special_res;
  logic            div_zero, div_ovf;
  logic [SW-1:0]   shamt;

  assign in_ready  = !rst && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign fire      = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign busy      = (state_reg == CALC);
  assign shamt     = opb[SW-1:0];

  always_comb begin
    case (alu_ctrl)
      ALU_CTRL_W'(ALU_ADD):  alu_res = opa + opb;
      ALU_CTRL_W'(ALU_SUB):  alu_res = opa - opb;
      ALU_CTRL_W'(ALU_SLL):  alu_res = opa << shamt;
      ALU_CTRL_W'(ALU_SLT):  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_CTRL_W'(ALU_SLTU): alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_CTRL_W'(ALU_XOR):  alu_res = opa ^ opb;
      ALU_CTRL_W'(ALU_SRL):  alu_res = opa >> shamt;
      ALU_CTRL_W'(ALU_SRA):  alu_res = $signed(opa) >>> shamt;
      ALU_CTRL_W'(ALU_OR):   alu_res = opa | opb;
      ALU_CTRL_W'(ALU_AND):  alu_res = opa & opb;
      default:               alu_res = '0;
    endcase
  end

  // Divide corner cases finish without iterating; md_op[1] selects remainder, md_op[0] unsigned.
  assign div_zero    = md_op[2] && (opb == '0);
  assign div_ovf     = md_op[2] && !md_op[0] && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (&opb);
  assign special_res = div_zero ? (md_op[1] ? opa : '1) : (md_op[1] ? '0 : opa);

  ysyx_25020032_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (iter_load),
    .step  (iter_step),
    .md_op (md_op),
    .opa   (opa),
    .opb   (opb),
    .last  (iter_last),
    .res   (iter_res)
  );

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    result_next    = result_reg;
    iter_load      = 1'b0;
    iter_step      = 1'b0;
    if (out_valid_reg && out_ready) out_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fire) begin
          if (!md_en) begin
            result_next    = alu_res;
            out_valid_next = 1'b1;
          end else if (div_zero || div_ovf) begin
            result_next    = special_res;
            out_valid_next = 1'b1;
          end else begin
            iter_load  = 1'b1;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        iter_step = 1'b1;
        if (iter_last) begin
          state_next     = DONE;
          result_next    = iter_res;
          out_valid_next = 1'b1;
        end
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
      result_next    = result_reg;
      iter_load      = 1'b0;
      iter_step      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
    end
  end

endmodule

// File: tb/tb_ysyx_25020032_exu_md.sv
// Directed bench for ysyx_25020032_exu_md: expectations queued at issue, checked by an output monitor.
`timescale 1ns/1ps
module tb_ysyx_25020032_exu_md;
  import ysyx_25020032_pkg::*;

  localparam int XLEN = 32;
  localparam int ALU_CTRL_W = 4;
`ifdef YSYX_25020032_EXU_MD_EARLY_EN
  localparam int DIV_LAT = -1;
`else
  localparam int DIV_LAT = XLEN + 1;
`endif
  localparam int MUL_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            md_en = 1'b0;
  logic [3:0]      alu_ctrl = '0;
  logic [2:0]      md_op = '0;
  logic [XLEN-1:0] opa = '0, opb = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            busy;

  ysyx_25020032_exu_md #(.XLEN(XLEN), .ALU_CTRL_W(ALU_CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .md_en(md_en), .alu_ctrl(alu_ctrl), .md_op(md_op), .opa(opa), .opb(opb),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    int              acc_cyc;
    string           name;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: latency checked when a new result appears, value checked on handshake.
  logic prev_v = 1'b0, prev_fire = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && (!prev_v || prev_fire)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got result %0h, expected no output", result);
        end else if (sb_q[0].lat >= 0) begin
          check({sb_q[0].name, "_lat"}, 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
        end
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        check({sb_q[0].name, "_res"}, 64'(result), 64'(sb_q[0].res));
        $display("txn %s: result=%08h expected=%08h cycles=%0d", sb_q[0].name, result,
                 sb_q[0].res, cyc - sb_q[0].acc_cyc);
        void'(sb_q.pop_front());
      end
    end
    prev_v    = out_valid;
    prev_fire = out_valid && out_ready;
  end

  task automatic issue(input logic md, input logic [3:0] ctrl, input logic [2:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic want,
                       input logic [XLEN-1:0] exp, input int lat, input string name,
                       output int waits);
    exp_t e;
    waits = 0;
    md_en = md; alu_ctrl = ctrl; md_op = op; opa = a; opb = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
    if (want) begin
      e.res = exp; e.lat = lat; e.acc_cyc = cyc; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() > 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  int w;
  int g;

  initial begin
    // Reset
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ALU ops, back-to-back with out_ready held high
    issue(1'b0, ALU_ADD, 3'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1, "add", w);
    issue(1'b0, ALU_SUB, 3'd0, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1, "sub", w);
    check("b2b_sub_nowait", 64'(w), 64'd0);
    issue(1'b0, ALU_SLT, 3'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd1, 1, "slt", w);
    check("b2b_slt_nowait", 64'(w), 64'd0);
    issue(1'b0, ALU_SLTU, 3'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 1, "sltu", w);
    issue(1'b0, ALU_SRA, 3'd0, 32'h80000000, 32'd4, 1'b1, 32'hF8000000, 1, "sra", w);
    issue(1'b0, ALU_SRL, 3'd0, 32'h80000000, 32'd4, 1'b1, 32'h08000000, 1, "srl", w);
    issue(1'b0, ALU_SLL, 3'd0, 32'd1, 32'd31, 1'b1, 32'h80000000, 1, "sll", w);
    issue(1'b0, ALU_XOR, 3'd0, 32'h0000F0F0, 32'h0000FF00, 1'b1, 32'h00000FF0, 1, "xor", w);
    issue(1'b0, ALU_OR, 3'd0, 32'h0000F0F0, 32'h0000FF00, 1'b1, 32'h0000FFF0, 1, "or", w);
    issue(1'b0, ALU_AND, 3'd0, 32'h0000F0F0, 32'h0000FF00, 1'b1, 32'h0000F000, 1, "and", w);
    drain();

    // Multiplies
    issue(1'b1, 4'd0, MD_MUL, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFE, MUL_LAT, "mul", w);
    issue(1'b1, 4'd0, MD_MULHU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h00000001, MUL_LAT, "mulhu", w);
    issue(1'b1, 4'd0, MD_MULH, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, MUL_LAT, "mulh", w);
    issue(1'b1, 4'd0, MD_MULHSU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, MUL_LAT, "mulhsu", w);
    issue(1'b1, 4'd0, MD_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, MUL_LAT, "mul_neg", w);
    issue(1'b1, 4'd0, MD_MULH, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, MUL_LAT, "mulh_min", w);

    // Divide corner cases: single-cycle
    issue(1'b1, 4'd0, MD_DIV, 32'd7, 32'd0, 1'b1, 32'hFFFFFFFF, 1, "div_by0", w);
    issue(1'b1, 4'd0, MD_REM, 32'd7, 32'd0, 1'b1, 32'd7, 1, "rem_by0", w);
    issue(1'b1, 4'd0, MD_DIVU, 32'd7, 32'd0, 1'b1, 32'hFFFFFFFF, 1, "divu_by0", w);
    issue(1'b1, 4'd0, MD_REMU, 32'd7, 32'd0, 1'b1, 32'd7, 1, "remu_by0", w);
    issue(1'b1, 4'd0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1, "div_ovf", w);
    issue(1'b1, 4'd0, MD_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 1, "rem_ovf", w);

    // Iterative divides
    issue(1'b1, 4'd0, MD_DIV, 32'hFFFFFFEC, 32'd3, 1'b1, 32'hFFFFFFFA, DIV_LAT, "div_neg", w);
    issue(1'b1, 4'd0, MD_REM, 32'hFFFFFFEC, 32'd3, 1'b1, 32'hFFFFFFFE, DIV_LAT, "rem_neg", w);
    issue(1'b1, 4'd0, MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, DIV_LAT, "div_negb", w);
    issue(1'b1, 4'd0, MD_REM, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, DIV_LAT, "rem_negb", w);
    issue(1'b1, 4'd0, MD_REMU, 32'd100, 32'd7, 1'b1, 32'd2, DIV_LAT, "remu", w);
    issue(1'b1, 4'd0, MD_DIVU, 32'hFFFFFFFF, 32'h10, 1'b1, 32'h0FFFFFFF, DIV_LAT, "divu_big", w);
    issue(1'b1, 4'd0, MD_DIV, 32'h80000000, 32'd2, 1'b1, 32'hC0000000, DIV_LAT, "div_min2", w);
    drain();

    // Backpressure: result must hold for 5 cycles with in_ready low
    out_ready = 1'b0;
    issue(1'b1, 4'd0, MD_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, DIV_LAT, "divu_bp", w);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("bp_done_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd14);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_released_valid", 64'(out_valid), 64'd0);
    check("bp_released_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Flush on cycle 10 of a DIV
    issue(1'b1, 4'd0, MD_DIV, 32'd1000, 32'd3, 1'b0, '0, 0, "div_flush", w);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    // Flush wins over a same-cycle ALU request
    md_en = 1'b0; alu_ctrl = ALU_ADD; opa = 32'd1; opb = 32'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_beats_in_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset mid-CALC abandons the op
    issue(1'b1, 4'd0, MD_MUL, 32'd3, 32'd5, 1'b0, '0, 0, "mul_rst", w);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    issue(1'b0, ALU_ADD, 3'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1, "add_after_rst", w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
